map_table: RTL and testbench

Register-rename map table for the 3-wide P6-style core. It sits directly upstream of the reservation station (RS) in the dispatch stage. For each of up to three dispatching instructions it reports whether each source register is renamed (hit), whether the producing ROB entry already holds its value (ready, "+"), and which ROB tag produces it. It also renames each destination register to its newly allocated ROB tag, marks entries ready on CDB broadcast, and clears entries on retirement.

---
 rtl/map_table_if.sv | 50 +++++
 rtl/map_table.sv | 140 ++++++++++++++
 tb/tb_map_table.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/map_table_if.sv
// Dispatch-side bundle for the rename map table:
// lookups, renames, CDB completions and retirements.
interface map_table_if #(
    parameter int ROB_SIZE = 32
);
    localparam int TW = $clog2(ROB_SIZE);

    logic                 flush;
    logic                 dispatch_en;
    logic [2:0]           slot_valid;
    logic [2:0][4:0]      rs1_idx;
    logic [2:0][4:0]      rs2_idx;
    logic [2:0][4:0]      rd_idx;
    logic [2:0]           rd_valid;
    logic [TW-1:0]        ROB_tail;
    logic                 complete_en;
    logic [2:0][TW-1:0]   CDB_tag;
    logic [2:0]           CDB_valid;
    logic [2:0]           retire_valid;
    logic [2:0][TW-1:0]   retire_tag;
    logic [2:0][4:0]      retire_rd;
    logic [2:0][TW-1:0]   MAP_TABLE_tag1;
    logic [2:0][TW-1:0]   MAP_TABLE_tag2;
    logic [2:0]           MAP_TABLE_hit1;
    logic [2:0]           MAP_TABLE_hit2;
    logic [2:0]           MAP_TABLE_ready1;
    logic [2:0]           MAP_TABLE_ready2;

    modport master (
        output flush, dispatch_en, slot_valid,
        output rs1_idx, rs2_idx, rd_idx, rd_valid,
        output ROB_tail, complete_en, CDB_tag,
        output CDB_valid, retire_valid,
        output retire_tag, retire_rd,
        input  MAP_TABLE_tag1, MAP_TABLE_tag2,
        input  MAP_TABLE_hit1, MAP_TABLE_hit2,
        input  MAP_TABLE_ready1, MAP_TABLE_ready2
    );

    modport slave (
        input  flush, dispatch_en, slot_valid,
        input  rs1_idx, rs2_idx, rd_idx, rd_valid,
        input  ROB_tail, complete_en, CDB_tag,
        input  CDB_valid, retire_valid,
        input  retire_tag, retire_rd,
        output MAP_TABLE_tag1, MAP_TABLE_tag2,
        output MAP_TABLE_hit1, MAP_TABLE_hit2,
        output MAP_TABLE_ready1, MAP_TABLE_ready2
    );
endinterface

// File: rtl/map_table.sv
// Register rename map table for a 3-wide dispatch group,
// with intra-group bypass, CDB ready marking and retire clear.
module map_table #(
    parameter int ROB_SIZE = 32,
    parameter int NUM_REGS = 32
) (
    input  logic       clk,
    input  logic       reset,
    map_table_if.slave mt
);
    localparam int TW = $clog2(ROB_SIZE);

    typedef struct packed {
        logic          hit;
        logic          ready;
        logic [TW-1:0] tag;
    } ent_t;

    logic [NUM_REGS-1:0]         hit_q;
    logic [NUM_REGS-1:0]         hit_d;
    logic [NUM_REGS-1:0]         ready_q;
    logic [NUM_REGS-1:0]         ready_d;
    logic [NUM_REGS-1:0][TW-1:0] tag_q;
    logic [NUM_REGS-1:0][TW-1:0] tag_d;

    logic [2:0][TW-1:0] slot_tag;
    logic [2:0]         wr_en;
    logic [2:0][4:0]    rd_idx;
    logic [TW:0]        tag_sum;
    ent_t               e1;
    ent_t               e2;

    assign rd_idx = mt.rd_idx;

    // Slot i is allocated tail+i+1, wrapped for any ROB depth.
    always_comb begin
        slot_tag = '0;
        wr_en    = '0;
        tag_sum  = '0;
        for (int i = 0; i < 3; i++) begin
            tag_sum = {1'b0, mt.ROB_tail} + (TW+1)'(i + 1);
            if (tag_sum >= (TW+1)'(ROB_SIZE))
                tag_sum = tag_sum - (TW+1)'(ROB_SIZE);
            slot_tag[i] = tag_sum[TW-1:0];
            wr_en[i] = mt.dispatch_en & mt.slot_valid[i]
                     & mt.rd_valid[i] & (rd_idx[i] != 5'd0);
        end
    end

    function automatic ent_t lookup(
        input logic [4:0] src,
        input int         slot
    );
        ent_t e;
        e = '0;
        if (src != 5'd0 && int'(src) < NUM_REGS) begin
            e.hit   = hit_q[src];
            e.ready = ready_q[src];
            e.tag   = tag_q[src];
        end
        // Ascending scan so the nearest older slot wins.
        for (int j = 0; j < 3; j++) begin
            if (j < slot && wr_en[j] && rd_idx[j] == src) begin
                e.hit   = 1'b1;
                e.ready = 1'b0;
                e.tag   = slot_tag[j];
            end
        end
        return e;
    endfunction

    always_comb begin
        mt.MAP_TABLE_hit1   = '0;
        mt.MAP_TABLE_ready1 = '0;
        mt.MAP_TABLE_tag1   = '0;
        mt.MAP_TABLE_hit2   = '0;
        mt.MAP_TABLE_ready2 = '0;
        mt.MAP_TABLE_tag2   = '0;
        e1 = '0;
        e2 = '0;
        for (int i = 0; i < 3; i++) begin
            e1 = lookup(mt.rs1_idx[i], i);
            e2 = lookup(mt.rs2_idx[i], i);
            mt.MAP_TABLE_hit1[i]   = e1.hit;
            mt.MAP_TABLE_ready1[i] = e1.ready;
            mt.MAP_TABLE_tag1[i]   = e1.tag;
            mt.MAP_TABLE_hit2[i]   = e2.hit;
            mt.MAP_TABLE_ready2[i] = e2.ready;
            mt.MAP_TABLE_tag2[i]   = e2.tag;
        end
    end

    // Later assignments override: CDB < retire < rename < flush.
    always_comb begin
        hit_d   = hit_q;
        ready_d = ready_q;
        tag_d   = tag_q;
        for (int r = 1; r < NUM_REGS; r++) begin
            for (int l = 0; l < 3; l++) begin
                if (mt.complete_en && mt.CDB_valid[l] && hit_q[r]
                    && tag_q[r] == mt.CDB_tag[l])
                    ready_d[r] = 1'b1;
            end
            for (int l = 0; l < 3; l++) begin
                if (mt.retire_valid[l]
                    && int'(mt.retire_rd[l]) == r
                    && hit_q[r]
                    && tag_q[r] == mt.retire_tag[l]) begin
                    hit_d[r]   = 1'b0;
                    ready_d[r] = 1'b0;
                    tag_d[r]   = '0;
                end
            end
            for (int s = 0; s < 3; s++) begin
                if (wr_en[s] && int'(rd_idx[s]) == r) begin
                    hit_d[r]   = 1'b1;
                    ready_d[r] = 1'b0;
                    tag_d[r]   = slot_tag[s];
                end
            end
        end
        if (mt.flush) begin
            hit_d   = '0;
            ready_d = '0;
            tag_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hit_q   <= '0;
            ready_q <= '0;
            tag_q   <= '0;
        end else begin
            hit_q   <= hit_d;
            ready_q <= ready_d;
            tag_q   <= tag_d;
        end
    end
endmodule

// File: tb/tb_map_table.sv
// Bench for map_table: directed vectors with literal expectations
// plus a per-cycle comparison against a behavioural rename table.
module tb_map_table;
    localparam int RS = 32;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    map_table_if #(.ROB_SIZE(RS)) mt();

    map_table #(.ROB_SIZE(RS), .NUM_REGS(32)) dut (
        .clk  (clk),
        .reset(reset),
        .mt   (mt)
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    int m_hit[32];
    int m_ready[32];
    int m_tag[32];
    int o_hit[32];
    int o_tag[32];

    // Behavioural table: apply the edge's events from lowest to highest priority.
    always @(posedge clk) begin
        if (!reset || mt.flush) begin
            for (int r = 0; r < 32; r++) begin
                m_hit[r] = 0; m_ready[r] = 0; m_tag[r] = 0;
            end
        end else begin
            o_hit = m_hit;
            o_tag = m_tag;
            for (int l = 0; l < 3; l++)
                if (mt.complete_en && mt.CDB_valid[l])
                    for (int r = 1; r < 32; r++)
                        if (o_hit[r] != 0 && o_tag[r] == int'(mt.CDB_tag[l]))
                            m_ready[r] = 1;
            for (int l = 0; l < 3; l++)
                if (mt.retire_valid[l]) begin
                    int r;
                    r = int'(mt.retire_rd[l]);
                    if (r != 0 && o_hit[r] != 0 && o_tag[r] == int'(mt.retire_tag[l]))
                        m_hit[r] = 0;
                end
            for (int s = 0; s < 3; s++)
                if (mt.dispatch_en && mt.slot_valid[s] && mt.rd_valid[s]
                    && mt.rd_idx[s] != 5'd0) begin
                    m_hit[int'(mt.rd_idx[s])]   = 1;
                    m_ready[int'(mt.rd_idx[s])] = 0;
                    m_tag[int'(mt.rd_idx[s])]   = (int'(mt.ROB_tail) + s + 1) % RS;
                end
        end
    end

    function automatic logic [6:0] exp_lu(int slot, int src);
        if (src == 0) return 7'd0;
        for (int j = slot - 1; j >= 0; j--)
            if (mt.dispatch_en && mt.slot_valid[j] && mt.rd_valid[j]
                && int'(mt.rd_idx[j]) == src)
                return {2'b10, 5'((int'(mt.ROB_tail) + j + 1) % RS)};
        return {1'(m_hit[src]), 1'(m_ready[src]), 5'(m_tag[src])};
    endfunction

    function automatic logic [6:0] act_lu(int slot, int k);
        if (k == 0)
            return {mt.MAP_TABLE_hit1[slot], mt.MAP_TABLE_ready1[slot],
                    mt.MAP_TABLE_tag1[slot]};
        return {mt.MAP_TABLE_hit2[slot], mt.MAP_TABLE_ready2[slot],
                mt.MAP_TABLE_tag2[slot]};
    endfunction

    function automatic int src_of(int slot, int k);
        return (k == 0) ? int'(mt.rs1_idx[slot]) : int'(mt.rs2_idx[slot]);
    endfunction

    // Ready and tag only mean something when hit, except for r0 which is all-zero.
    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 3; i++) begin
                for (int k = 0; k < 2; k++) begin
                    logic [6:0] a, e;
                    int s;
                    bit bad;
                    s = src_of(i, k);
                    a = act_lu(i, k);
                    e = exp_lu(i, s);
                    bad = (e[6] || s == 0) ? (a != e) : (a[6] != e[6]);
                    n_vec++;
                    if (bad) begin
                        n_err++;
                        $display("FAIL model_s%0d_rs%0d r%0d @%0t: got hit=%b ready=%b tag=%0d, want hit=%b ready=%b tag=%0d",
                                 i, k + 1, s, $time, a[6], a[5], a[4:0], e[6], e[5], e[4:0]);
                    end
                end
            end
        end
    end

    task automatic lit(string nm, int slot, int k, int h, int rd, int tg);
        logic [6:0] a, m;
        a = act_lu(slot, k);
        m = exp_lu(slot, src_of(slot, k));
        n_vec++;
        if (a[6] != 1'(h) || (h != 0 && (a[5] != 1'(rd) || int'(a[4:0]) != tg))) begin
            n_err++;
            $display("FAIL %s: dut hit=%b ready=%b tag=%0d, want hit=%0d ready=%0d tag=%0d",
                     nm, a[6], a[5], a[4:0], h, rd, tg);
        end
        n_vec++;
        if (m[6] != 1'(h) || (h != 0 && (m[5] != 1'(rd) || int'(m[4:0]) != tg))) begin
            n_err++;
            $display("FAIL %s_model: model hit=%b ready=%b tag=%0d, want hit=%0d ready=%0d tag=%0d",
                     nm, m[6], m[5], m[4:0], h, rd, tg);
        end
    endtask

    task automatic idle();
        mt.flush = 1'b0;
        mt.dispatch_en = 1'b0;
        mt.slot_valid = '0;
        mt.rs1_idx = '0;
        mt.rs2_idx = '0;
        mt.rd_idx = '0;
        mt.rd_valid = '0;
        mt.ROB_tail = '0;
        mt.complete_en = 1'b0;
        mt.CDB_tag = '0;
        mt.CDB_valid = '0;
        mt.retire_valid = '0;
        mt.retire_tag = '0;
        mt.retire_rd = '0;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic dispatch(int tail, logic [2:0] sv, logic [2:0] rv);
        mt.dispatch_en = 1'b1;
        mt.ROB_tail = 5'(tail);
        mt.slot_valid = sv;
        mt.rd_valid = rv;
    endtask

    initial begin
        idle();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        chk_on = 1'b1;

        for (int i = 0; i < 3; i++) begin
            mt.rs1_idx[i] = 5'd5;
            mt.rs2_idx[i] = 5'd6;
        end
        mid();
        lit("post_reset_s0_rs1", 0, 0, 0, 0, 0);
        lit("post_reset_s2_rs2", 2, 1, 0, 0, 0);
        nxt();

        dispatch(3, 3'b111, 3'b101);
        mt.rd_idx[0] = 5'd5;
        mt.rs1_idx[1] = 5'd5;
        mt.rs2_idx[2] = 5'd5;
        mt.rd_idx[2] = 5'd5;
        mid();
        lit("bypass_s1_rs1", 1, 0, 1, 0, 4);
        lit("bypass_s2_rs2", 2, 1, 1, 0, 4);
        nxt();

        mt.rs1_idx[0] = 5'd5;
        mt.complete_en = 1'b1;
        mt.CDB_valid = 3'b001;
        mt.CDB_tag[0] = 5'd4;
        mid();
        lit("r5_renamed", 0, 0, 1, 0, 6);
        nxt();

        mt.rs1_idx[0] = 5'd5;
        mt.complete_en = 1'b1;
        mt.CDB_valid = 3'b001;
        mt.CDB_tag[0] = 5'd6;
        mid();
        lit("cdb4_not_ready", 0, 0, 1, 0, 6);
        nxt();

        mt.rs1_idx[0] = 5'd5;
        mt.retire_valid = 3'b001;
        mt.retire_tag[0] = 5'd4;
        mt.retire_rd[0] = 5'd5;
        mid();
        lit("cdb6_ready", 0, 0, 1, 1, 6);
        nxt();

        mt.rs1_idx[0] = 5'd5;
        mt.retire_valid = 3'b010;
        mt.retire_tag[1] = 5'd6;
        mt.retire_rd[1] = 5'd5;
        mid();
        lit("stale_retire", 0, 0, 1, 1, 6);
        nxt();

        mt.rs1_idx[0] = 5'd5;
        dispatch(1, 3'b001, 3'b001);
        mt.rd_idx[0] = 5'd7;
        mid();
        lit("retire_clear", 0, 0, 0, 0, 0);
        nxt();

        mt.rs1_idx[0] = 5'd7;
        dispatch(8, 3'b001, 3'b001);
        mt.rd_idx[0] = 5'd7;
        mt.complete_en = 1'b1;
        mt.CDB_valid = 3'b001;
        mt.CDB_tag[0] = 5'd2;
        mt.retire_valid = 3'b001;
        mt.retire_tag[0] = 5'd2;
        mt.retire_rd[0] = 5'd7;
        mid();
        lit("r7_old", 0, 0, 1, 0, 2);
        nxt();

        mt.rs1_idx[0] = 5'd7;
        dispatch(20, 3'b111, 3'b011);
        mt.rd_idx[0] = 5'd9;
        mt.rd_idx[1] = 5'd9;
        mt.rs1_idx[1] = 5'd9;
        mt.rs1_idx[2] = 5'd9;
        mt.rs2_idx[1] = 5'd0;
        mid();
        lit("simultaneous", 0, 0, 1, 0, 9);
        lit("nearest_s1", 1, 0, 1, 0, 21);
        lit("nearest_s2", 2, 0, 1, 0, 22);
        lit("r0_source", 1, 1, 0, 0, 0);
        nxt();

        dispatch(0, 3'b110, 3'b001);
        mt.rd_idx[0] = 5'd10;
        mt.rs1_idx[1] = 5'd10;
        mt.rs1_idx[2] = 5'd9;
        mid();
        lit("invalid_slot", 1, 0, 0, 0, 0);
        lit("r9_nearest", 2, 0, 1, 0, 22);
        nxt();

        dispatch(31, 3'b111, 3'b111);
        mt.rd_idx[0] = 5'd1;
        mt.rd_idx[1] = 5'd2;
        mt.rd_idx[2] = 5'd3;
        nxt();

        for (int i = 0; i < 3; i++) mt.rs1_idx[i] = 5'(i + 1);
        mt.flush = 1'b1;
        dispatch(5, 3'b001, 3'b001);
        mt.rd_idx[0] = 5'd4;
        mid();
        lit("wrap_0", 0, 0, 1, 0, 0);
        lit("wrap_1", 1, 0, 1, 0, 1);
        lit("wrap_2", 2, 0, 1, 0, 2);
        nxt();

        for (int i = 0; i < 3; i++) mt.rs1_idx[i] = 5'(i + 1);
        mt.rs2_idx[0] = 5'd4;
        mid();
        lit("flush_r1", 0, 0, 0, 0, 0);
        lit("flush_r3", 2, 0, 0, 0, 0);
        lit("flush_beats_rename", 0, 1, 0, 0, 0);
        nxt();

        dispatch(10, 3'b011, 3'b011);
        mt.rd_idx[0] = 5'd4;
        mt.rd_idx[1] = 5'd8;
        nxt();

        mt.rs1_idx[0] = 5'd4;
        mt.rs2_idx[0] = 5'd8;
        dispatch(15, 3'b001, 3'b001);
        mt.rd_idx[0] = 5'd12;
        reset = 1'b0;
        mid();
        lit("pre_reset_r4", 0, 0, 1, 0, 11);
        lit("pre_reset_r8", 0, 1, 1, 0, 12);
        nxt();
        reset = 1'b1;

        mt.rs1_idx[0] = 5'd4;
        mt.rs2_idx[0] = 5'd8;
        mt.rs1_idx[1] = 5'd12;
        mid();
        lit("reset_r4", 0, 0, 0, 0, 0);
        lit("reset_r8", 0, 1, 0, 0, 0);
        lit("reset_r12", 1, 0, 0, 0, 0);
        nxt();

        // Dense mixed traffic on a few registers and tags, checked by the model.
        for (int c = 0; c < 80; c++) begin
            dispatch($urandom_range(0, 7), 3'($urandom), 3'($urandom));
            mt.dispatch_en = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 3; i++) begin
                mt.rs1_idx[i] = 5'($urandom_range(0, 5));
                mt.rs2_idx[i] = 5'($urandom_range(0, 5));
                mt.rd_idx[i] = 5'($urandom_range(0, 5));
                mt.CDB_tag[i] = 5'($urandom_range(0, 10));
                mt.retire_tag[i] = 5'($urandom_range(0, 10));
                mt.retire_rd[i] = 5'($urandom_range(0, 5));
            end
            mt.complete_en = 1'($urandom);
            mt.CDB_valid = 3'($urandom);
            mt.retire_valid = 3'($urandom);
            mt.flush = ($urandom_range(0, 19) == 0);
            nxt();
        end

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
